// File: rtl/seven_segment_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scan_counter
// Purpose  : N-digit hex/BCD up/down counter, multiplexed onto a
//            common-anode seven-segment display. Optional leading-zero
//            blanking via SEVEN_SEG_LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scan_counter #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_COUNT = 100000,
    parameter int TICK_DIV      = 100000000
) (
    input  logic                    clk_100_Mhz,
    input  logic                    reset,
    input  logic                    count_enable,
    input  logic                    count_up,
    input  logic                    mode_bcd,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [NUM_DIGITS-1:0]   anode_bits,
    output logic [6:0]              seven_segments_LED_output,
    output logic [3:0]              LED_binary_coded_decimal,
    output logic [4*NUM_DIGITS-1:0] HEX_display_digits,
    output logic                    wrap
);

    localparam int CW        = 4 * NUM_DIGITS;
    localparam int SCAN_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REFRESH_W = $clog2(REFRESH_COUNT);
    localparam int TICK_W    = $clog2(TICK_DIV);

    logic [REFRESH_W-1:0] refresh_q, refresh_d;
    logic [SCAN_W-1:0]    scan_q, scan_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 wrap_q, wrap_d;
    logic                 mode_prev_q;

    logic                 tick;
    logic [CW-1:0]        bcd_next;
    logic                 bcd_carry;
    logic [CW-1:0]        load_sat;
    logic [3:0]           nib;
    logic [6:0]           seg_raw;

    always_comb begin
        refresh_d = refresh_q + REFRESH_W'(1);
        scan_d    = scan_q;
        if (refresh_q == REFRESH_W'(REFRESH_COUNT - 1)) begin
            refresh_d = '0;
            scan_d    = (scan_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_q + SCAN_W'(1);
        end
        tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    // Decimal ripple: carry (up) or borrow (down) propagates while digits roll over.
    always_comb begin
        bcd_next  = count_q;
        bcd_carry = 1'b1;
        load_sat  = load_value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_carry) begin
                if (count_up) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        bcd_next[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_next[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        bcd_carry          = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        bcd_next[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_next[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        bcd_carry          = 1'b0;
                    end
                end
            end
            if (load_value[4*i +: 4] > 4'd9) begin
                load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (mode_bcd != mode_prev_q) begin
            count_d = '0;
        end else if (load) begin
            count_d = mode_bcd ? load_sat : load_value;
        end else if (tick && count_enable) begin
            if (mode_bcd) begin
                count_d = bcd_next;
                wrap_d  = bcd_carry;
            end else if (count_up) begin
                count_d = count_q + CW'(1);
                wrap_d  = &count_q;
            end else begin
                count_d = count_q - CW'(1);
                wrap_d  = ~|count_q;
            end
        end
    end

    // Previous mode tracks the input even in reset so release never looks like a mode change.
    always_ff @(posedge clk_100_Mhz) begin
        mode_prev_q <= mode_bcd;
        if (reset) begin
            refresh_q  <= '0;
            scan_q     <= '0;
            tick_cnt_q <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            refresh_q  <= refresh_d;
            scan_q     <= scan_d;
            tick_cnt_q <= tick_cnt_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
        end
    end

    assign nib = count_q[4*scan_q +: 4];

    always_comb begin
        case (nib)
            4'h0:    seg_raw = 7'b0000001;
            4'h1:    seg_raw = 7'b1001111;
            4'h2:    seg_raw = 7'b0010010;
            4'h3:    seg_raw = 7'b0000110;
            4'h4:    seg_raw = 7'b1001100;
            4'h5:    seg_raw = 7'b0100100;
            4'h6:    seg_raw = 7'b0100000;
            4'h7:    seg_raw = 7'b0001111;
            4'h8:    seg_raw = 7'b0000000;
            4'h9:    seg_raw = 7'b0000100;
            4'hA:    seg_raw = 7'b0001000;
            4'hB:    seg_raw = 7'b1100000;
            4'hC:    seg_raw = 7'b0110001;
            4'hD:    seg_raw = 7'b1000010;
            4'hE:    seg_raw = 7'b0110000;
            default: seg_raw = 7'b0111000;
        endcase
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;
    logic                  upper_zero;

    // A digit is blank when it and every more-significant digit are zero; digit 0 always shows.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero & (count_q[4*i +: 4] == 4'd0);
            blank[i]   = upper_zero;
        end
    end

    assign seven_segments_LED_output = blank[scan_q] ? 7'b1111111 : seg_raw;
`else
    assign seven_segments_LED_output = seg_raw;
`endif

    assign anode_bits               = ~(NUM_DIGITS'(1) << scan_q);
    assign LED_binary_coded_decimal = nib;
    assign HEX_display_digits       = count_q;
    assign wrap                     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scan_counter
// Purpose  : Directed plus random checks of seven_segment_scan_counter
//            against a decimal/modular arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scan_counter;

    localparam int ND  = 4;
    localparam int RC  = 4;
    localparam int TD  = 8;
    localparam int CW  = 4 * ND;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          count_enable = 1'b0;
    logic          count_up = 1'b1;
    logic          mode_bcd = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] load_value = '0;
    logic [ND-1:0] anode_bits;
    logic [6:0]    seg;
    logic [3:0]    led_nib;
    logic [CW-1:0] hex_digits;
    logic          wrap;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_cyc = 0;
    int            m_val = 0;
    bit            m_wrap = 1'b0;
    bit            m_prev = 1'b0;
    bit            m_last_tick = 1'b0;

    logic [6:0] seg_tbl [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seven_segment_scan_counter #(
        .NUM_DIGITS   (ND),
        .REFRESH_COUNT(RC),
        .TICK_DIV     (TD)
    ) dut (
        .clk_100_Mhz              (clk),
        .reset                    (reset),
        .count_enable             (count_enable),
        .count_up                 (count_up),
        .mode_bcd                 (mode_bcd),
        .load                     (load),
        .load_value               (load_value),
        .anode_bits               (anode_bits),
        .seven_segments_LED_output(seg),
        .LED_binary_coded_decimal (led_nib),
        .HEX_display_digits       (hex_digits),
        .wrap                     (wrap)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input int v);
        int r = 0;
        int w = 1;
        for (int i = 0; i < ND; i++) begin
            r += ((v >> (4 * i)) & 15) * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic int int2bcd(input int d);
        int r = 0;
        for (int i = 0; i < ND; i++) begin
            r |= (d % 10) << (4 * i);
            d /= 10;
        end
        return r;
    endfunction

    function automatic int sat_bcd(input int v);
        int r = 0;
        for (int i = 0; i < ND; i++) begin
            int n = (v >> (4 * i)) & 15;
            r |= ((n > 9) ? 9 : n) << (4 * i);
        end
        return r;
    endfunction

    function automatic int cur_scan();
        return (m_cyc / RC) % ND;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int         s   = cur_scan();
        int         n   = (m_val >> (4 * s)) & 15;
        logic [6:0] es  = seg_tbl[n];
        logic [3:0] ea  = ~(4'b0001 << s);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (s > 0 && (m_val >> (4 * s)) == 0) es = 7'b1111111;
`endif
        check("anode", 32'(anode_bits), 32'(ea));
        check("nibble", 32'(led_nib), n);
        check("segments", 32'(seg), 32'(es));
        check("hex", 32'(hex_digits), m_val);
        check("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    // One clock: model predicts from the sampled inputs, then all outputs are compared.
    task automatic step();
        int nv  = m_val;
        bit nw  = 1'b0;
        bit tk  = 1'b0;
        int mod = mode_bcd ? 10000 : 65536;
        int d;
        if (reset) begin
            nv = 0;
        end else begin
            tk = (m_cyc % TD) == TD - 1;
            if (mode_bcd != m_prev) begin
                nv = 0;
                tk = 1'b0;
            end else if (load) begin
                nv = mode_bcd ? sat_bcd(int'(load_value)) : int'(load_value);
                tk = 1'b0;
            end else if (tk && count_enable) begin
                d  = mode_bcd ? bcd2int(m_val) : m_val;
                nw = count_up ? (d == mod - 1) : (d == 0);
                d  = count_up ? (d + 1) % mod : (d + mod - 1) % mod;
                nv = mode_bcd ? int2bcd(d) : d;
            end else begin
                tk = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_cyc       = reset ? 0 : m_cyc + 1;
        m_val       = nv;
        m_wrap      = nw;
        m_prev      = mode_bcd;
        m_last_tick = tk;
        check_all();
    endtask

    task automatic wait_tick(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 4 * TD; k++) begin
            step();
            if (m_last_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: no tick within %0d cycles", tag, 4 * TD);
        end
    endtask

    initial begin
        // Reset for two cycles
        reset = 1'b1;
        step();
        step();
        check("rst_anode", 32'(anode_bits), 32'h0000000E);
        check("rst_seg", 32'(seg), 32'h01);
        check("rst_hex", 32'(hex_digits), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        reset = 1'b0;

        // Scan with counting disabled
        for (int k = 0; k < 16; k++) begin
            step();
            if (k == 3)  check("scan_d1", 32'(anode_bits), 32'h0000000D);
            if (k == 7)  check("scan_d2", 32'(anode_bits), 32'h0000000B);
            if (k == 11) check("scan_d3", 32'(anode_bits), 32'h00000007);
        end
        check("scan_back", 32'(anode_bits), 32'h0000000E);

        // BCD carry and BCD wrap
        mode_bcd = 1'b1;
        step();
        load = 1'b1; load_value = 16'h0099;
        step();
        load = 1'b0; count_up = 1'b1; count_enable = 1'b1;
        wait_tick("bcd_carry_tick");
        check("bcd_carry", 32'(hex_digits), 32'h0100);
        load = 1'b1; load_value = 16'h9999;
        step();
        load = 1'b0;
        wait_tick("bcd_wrap_tick");
        check("bcd_wrap_val", 32'(hex_digits), 32'h0000);
        check("bcd_wrap_pulse", 32'(wrap), 32'h1);
        step();
        check("bcd_wrap_clear", 32'(wrap), 32'h0);

        // Hex down-wrap
        mode_bcd = 1'b0;
        step();
        load = 1'b1; load_value = 16'h0000;
        step();
        load = 1'b0; count_up = 1'b0;
        wait_tick("hex_down_tick");
        check("hex_down_val", 32'(hex_digits), 32'hFFFF);
        check("hex_down_wrap", 32'(wrap), 32'h1);

        // Load coincident with tick wins
        count_up = 1'b1;
        for (int k = 0; k < TD && (m_cyc % TD) != TD - 1; k++) step();
        load = 1'b1; load_value = 16'h1234;
        step();
        check("load_vs_tick", 32'(hex_digits), 32'h1234);
        check("load_no_wrap", 32'(wrap), 32'h0);
        load = 1'b0;
        mode_bcd = 1'b1;
        step();
        load = 1'b1; load_value = 16'hABCD;
        step();
        check("bcd_load_sat", 32'(hex_digits), 32'h9999);
        load = 1'b0;

        // Reset mid-scan during count 0x0042
        mode_bcd = 1'b0; count_enable = 1'b0;
        step();
        load = 1'b1; load_value = 16'h0042;
        step();
        load = 1'b0;
        for (int k = 0; k < 2 * ND * RC && cur_scan() != 2; k++) step();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        check("blank_d2", 32'(seg), 32'h7F);
`else
        check("noblank_d2", 32'(seg), 32'h01);
`endif
        for (int k = 0; k < 2 * ND * RC && cur_scan() != 3; k++) step();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        check("blank_d3", 32'(seg), 32'h7F);
`else
        check("noblank_d3", 32'(seg), 32'h01);
`endif
        reset = 1'b1;
        step();
        check("mid_rst_anode", 32'(anode_bits), 32'h0000000E);
        check("mid_rst_seg", 32'(seg), 32'h01);
        check("mid_rst_hex", 32'(hex_digits), 32'h0);
        check("mid_rst_nib", 32'(led_nib), 32'h0);
        reset = 1'b0;

        // Random operation
        for (int k = 0; k < 600; k++) begin
            reset        = ($urandom_range(0, 99) == 0);
            load         = ($urandom_range(0, 9) == 0);
            load_value   = CW'($urandom);
            count_enable = ($urandom_range(0, 3) != 0);
            count_up     = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 29) == 0) mode_bcd = ~mode_bcd;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_segment_scan_counter.md
# seven_segment_scan_counter

Parametrised successor to the four-digit seven-segment display controller. It provides an N-digit up/down counter in hexadecimal or BCD mode, with synchronous load and a wrap pulse. It time-multiplexes the counter value onto a common-anode seven-segment display. It sits between board-level anode/segment pins and control logic that supplies enable, direction, mode and load.

## Interface
- NUM_DIGITS, 4: number of display digits (2..8); counter width is 4*NUM_DIGITS.
- REFRESH_COUNT, 100000: clk cycles each digit stays lit (1 ms at 100 MHz); ≥2.
- TICK_DIV, 100000000: clk cycles between count ticks (1 s at 100 MHz); ≥2.
- clk_100_Mhz  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- count_enable  in  1  1 = count on each tick.
- count_up  in  1  1 = increment, 0 = decrement.
- mode_bcd  in  1  1 = BCD (each digit 0–9), 0 = hexadecimal.
- load  in  1  synchronous load strobe.
- load_value  in  4*NUM_DIGITS  value loaded when load=1.
- anode_bits  out  NUM_DIGITS  active-low digit select, one-hot-low.
- seven_segments_LED_output  out  7  active-low segments, bit6=a … bit0=g.
- LED_binary_coded_decimal  out  4  nibble of the currently selected digit.
- HEX_display_digits  out  4*NUM_DIGITS  current counter value; digit 0 is [3:0].
- wrap  out  1  one-cycle pulse when the count wraps.

## Operation
- **Refresh counter** (0..REFRESH_COUNT-1):
  - At terminal value it clears and scan_index advances.
  - scan_index wraps from NUM_DIGITS-1 to 0.
- **Anode and nibble select:**
  - anode_bits = ~(1 << scan_index).
  - LED_binary_coded_decimal = HEX_display_digits[4*scan_index +: 4].
- **Segment encoding** (active low), 0..F:
  - 0–7: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111.
  - 8–F: 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- **Tick counter** (0..TICK_DIV-1):
  - Free-running; tick is asserted internally in the terminal cycle.
  - It runs regardless of count_enable.
- **Priority:** reset > load > (tick & count_enable) > hold.
- **Load:**
  - HEX_display_digits <= load_value.
  - In BCD mode, any nibble >9 is loaded as 9.
  - Load does not pulse wrap.
  - Load does not reset the tick or refresh counters.
- **Hex count:** modulo 2^(4*NUM_DIGITS) binary add or subtract of 1.
- **BCD count, up:** digit at 9 becomes 0 and carries into the next digit.
- **BCD count, down:** digit at 0 becomes 9 and borrows from the next digit.
- **Wrap:**
  - Up from all-F (hex) or all-9 (BCD) goes to 0, with wrap=1 for one cycle.
  - Down from 0 goes to all-F or all-9, with wrap=1.
- **Mode change:**
  - A change of mode_bcd clears HEX_display_digits to 0 on the following clock.
  - This clear takes priority over tick and load, but not over reset.
- **Invalid BCD nibble:** a >9 value present when mode_bcd rises is removed by the mode-change clear, so BCD mode never holds a >9 nibble.

## Timing
- **Reset values** (on the cycle after reset is sampled high):
  - refresh counter, tick counter, scan_index = 0.
  - HEX_display_digits = 0, LED_binary_coded_decimal = 0, wrap = 0.
  - anode_bits = all ones except bit0 = 0.
  - seven_segments_LED_output = 0000001.
- Reset mid-count or mid-scan aborts immediately; no partial state survives.
- Counter, scan_index and wrap are registered.
- anode_bits, LED_binary_coded_decimal and seven_segments_LED_output are combinational decodes of registered state. They change in the same cycle as scan_index or the counter, with no added latency.
- HEX_display_digits updates on the clock edge that samples the tick, load or mode change.
- wrap is high during the cycle after that edge.
- Full scan period = NUM_DIGITS*REFRESH_COUNT cycles.
- First tick arrives TICK_DIV cycles after reset release.

## Configuration
- **SEVEN_SEG_LEADING_ZERO_BLANK_EN defined:** blanking is compiled in.
  - Segments show 1111111 for any digit above the most-significant nonzero digit.
  - Digit 0 is never blanked.
  - anode_bits still scans normally.
  - LED_binary_coded_decimal still reports the true nibble.
- **Undefined:** all digits are always displayed, including leading zeros.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_COUNT=4, TICK_DIV=8.
- **Reset:** assert reset 2 cycles -> anode_bits=1110, segments=0000001, HEX_display_digits=0000, wrap=0.
- **Scan:** hold count_enable=0 for 16 cycles after reset -> anode_bits steps 1110, 1101, 1011, 0111 every 4 cycles, then back to 1110.
- **BCD carry:** mode_bcd=1, load 0x0099, count_up=1, count_enable=1 -> next tick gives 0x0100. With a load of 0x9999 -> next tick gives 0x0000 and wrap pulses for 1 cycle.
- **Hex down-wrap:** mode_bcd=0, load 0x0000, count_up=0 -> next tick gives 0xFFFF with wrap=1.
- **Priority, load vs tick:** load=1 coincident with tick, load_value 0x1234 -> 0x1234 (tick ignored). Load of 0xABCD in BCD mode -> 0x9999.
- **Reset mid-operation:** reset during count 0x0042 mid-scan -> all reset values next cycle. With the macro defined, 0x0042 shows segments 1111111 on digits 3 and 2.
